// File: rtl/llm_pkg.sv
// Types and constants shared between the phase scheduler and the light-monitor datapath.
package llm_pkg;

    localparam int TIMER_W = 6;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_e;

    // Entering a phase of duration D loads the down-counter with D-1.
    function automatic logic [TIMER_W-1:0] load_val(input int dur);
        return TIMER_W'(dur - 1);
    endfunction

    function automatic bit dur_ok(input int dur);
        return (dur >= 1) && (dur <= 63);
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request/override inputs and light/status outputs of the traffic phase scheduler.
interface traffic_phase_scheduler_if;
    import llm_pkg::*;

    logic               ped_req;
    logic               emergency;
    logic               green;
    logic               yellow;
    logic               red;
    logic               ped_ack;
    logic [1:0]         phase;
    logic [TIMER_W-1:0] timer;

    modport master (
        output ped_req, emergency,
        input  green, yellow, red, ped_ack, phase, timer
    );

    modport slave (
        input  ped_req, emergency,
        output green, yellow, red, ped_ack, phase, timer
    );

endinterface

// File: rtl/phase_timer.sv
// Down-counter for the current phase: load on phase entry, hold-reload while an override is active.
module phase_timer
    import llm_pkg::*;
#(
    parameter logic [TIMER_W-1:0] HOLD_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_hold,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    // Reset and hold share the same value: both mean "start a fresh RED".
    always_ff @(posedge clock) begin
        if (reset || i_hold) begin
            r_count <= HOLD_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// RED -> GREEN -> YELLOW light sequencer with pedestrian early-exit and emergency red hold.
module traffic_phase_scheduler
    import llm_pkg::*;
#(
    parameter int GREEN_TIME  = 40,
    parameter int YELLOW_TIME = 5,
    parameter int RED_TIME    = 20,
    parameter int MIN_GREEN   = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    traffic_phase_scheduler_if.slave  bus
);

    if (!dur_ok(GREEN_TIME) || !dur_ok(YELLOW_TIME) || !dur_ok(RED_TIME)
        || MIN_GREEN < 1 || MIN_GREEN > GREEN_TIME) begin : g_param_check
        $error("traffic_phase_scheduler: illegal phase duration parameters");
    end

    localparam logic [TIMER_W-1:0] L_RED    = load_val(RED_TIME);
    localparam logic [TIMER_W-1:0] L_GREEN  = load_val(GREEN_TIME);
    localparam logic [TIMER_W-1:0] L_YELLOW = load_val(YELLOW_TIME);
    localparam logic [TIMER_W:0]   L_GREEN_LEN = (TIMER_W+1)'(GREEN_TIME);
    localparam logic [TIMER_W:0]   L_MIN_GREEN = (TIMER_W+1)'(MIN_GREEN);

    phase_e             r_state;
    phase_e             w_state_next;
    logic               r_pending;
    logic               w_pending_next;
    logic               r_ped_ack;
    logic               w_ped_ack_next;
    logic               w_load;
    logic               w_hold;
    logic [TIMER_W-1:0] w_load_val;
    logic [TIMER_W-1:0] w_timer;
    logic               w_zero;
    logic [TIMER_W:0]   w_elapsed;
    logic               w_ped_exit;
    logic [2:0]         w_lights;

    phase_timer #(
        .HOLD_VAL   (L_RED)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_hold     (w_hold),
        .o_count    (w_timer),
        .o_zero     (w_zero)
    );

    // Extra bit keeps GREEN_TIME - timer from wrapping.
    assign w_elapsed  = L_GREEN_LEN - {1'b0, w_timer};
    assign w_ped_exit = r_pending && (w_elapsed >= L_MIN_GREEN);

    // A request in the acknowledge cycle re-arms pending instead of being lost.
    assign w_pending_next = bus.ped_req | (r_pending & ~r_ped_ack);

    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_load_val     = L_RED;
        w_hold         = 1'b0;
        w_ped_ack_next = 1'b0;
        case (r_state)
            PH_RED: begin
                if (bus.emergency) begin
                    w_hold = 1'b1;
                end else if (w_zero) begin
                    w_state_next = PH_GREEN;
                    w_load       = 1'b1;
                    w_load_val   = L_GREEN;
                end
            end
            PH_GREEN: begin
                if (bus.emergency || w_zero || w_ped_exit) begin
                    w_state_next = PH_YELLOW;
                    w_load       = 1'b1;
                    w_load_val   = L_YELLOW;
                end
            end
            PH_YELLOW: begin
                if (w_zero) begin
                    w_state_next   = PH_RED;
                    w_load         = 1'b1;
                    w_load_val     = L_RED;
                    w_ped_ack_next = w_pending_next;
                end
            end
            default: begin
                w_state_next = PH_RED;
                w_load       = 1'b1;
                w_load_val   = L_RED;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= PH_RED;
            r_pending <= 1'b0;
            r_ped_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_ped_ack <= w_ped_ack_next;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_light
        assign w_lights[gi] = (r_state == phase_e'(2'(gi)));
    end

    assign bus.red     = w_lights[PH_RED];
    assign bus.green   = w_lights[PH_GREEN];
    assign bus.yellow  = w_lights[PH_YELLOW];
    assign bus.phase   = r_state;
    assign bus.timer   = w_timer;
    assign bus.ped_ack = r_ped_ack;

endmodule
